// File: rtl/seq_pattern_tx_pkg.sv
// seq_pkg: shared FSM state type and width/pattern defaults for seq_pattern_tx.
// Optional feature macro: SEQ_TX_PARITY_EN (adds a trailing even-parity bit per repetition).
package seq_pkg;

    localparam int unsigned SEQ_PAT_W = 4;
    localparam int unsigned SEQ_CNT_W = 8;
    localparam int unsigned SEQ_GAP_W = 4;

    localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_pattern_tx_shifter.sv
// seq_tx_shifter: latched pattern, MSB-first shift register and per-repetition bit counter.
// With SEQ_TX_PARITY_EN the counter spans one extra slot and the even parity of the pattern is exported.
module seq_tx_shifter
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_shift,
    output logic             o_msb,
`ifdef SEQ_TX_PARITY_EN
    output logic             o_parity,
`endif
    output logic             o_last
);

`ifdef SEQ_TX_PARITY_EN
    localparam int unsigned BITS = PAT_W + 1;
`else
    localparam int unsigned BITS = PAT_W;
`endif
    localparam int unsigned    BCW      = $clog2(BITS);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(BITS - 1);

    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_sreg;
    logic [BCW-1:0]   r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST_IDX);
    assign o_last = w_last;
    assign o_msb  = r_sreg[PAT_W-1];
`ifdef SEQ_TX_PARITY_EN
    assign o_parity = ^r_pat;
`endif

    // The final slot reloads the register so back-to-back repetitions and gap exits need no extra control.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pat  <= PAT_W'(SEQ_DEFAULT_PATTERN);
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_pat  <= i_pattern;
            r_sreg <= i_pattern;
            r_cnt  <= '0;
        end else if (i_shift) begin
            if (w_last) begin
                r_sreg <= r_pat;
                r_cnt  <= '0;
            end else begin
                r_sreg <= {r_sreg[PAT_W-2:0], 1'b0};
                r_cnt  <= r_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeats a latched pattern MSB-first with idle-zero gaps; Moore FSM, registered outputs.
// Optional feature macro: SEQ_TX_PARITY_EN (one even-parity bit after each repetition's data bits).
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_PAT_W,
    parameter int unsigned CNT_W = SEQ_CNT_W,
    parameter int unsigned GAP_W = SEQ_GAP_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             sequence_out,
    output logic             sequence_valid,
    output logic             busy,
    output logic             done
);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [CNT_W-1:0] r_rep;
    logic [GAP_W-1:0] r_gap_len;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic w_load;
    logic w_shift;
    logic w_gap_enter;
    logic w_msb;
    logic w_last;
    logic w_bit;
    logic w_more;
`ifdef SEQ_TX_PARITY_EN
    logic w_parity;
`endif

    seq_tx_shifter #(
        .PAT_W (PAT_W)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_pattern (pattern_in),
        .i_shift   (w_shift),
        .o_msb     (w_msb),
`ifdef SEQ_TX_PARITY_EN
        .o_parity  (w_parity),
`endif
        .o_last    (w_last)
    );

`ifdef SEQ_TX_PARITY_EN
    assign w_bit = w_last ? w_parity : w_msb;
`else
    assign w_bit = w_msb;
`endif

    assign w_more = (r_rep > CNT_W'(1));

    // Gating on r_busy keeps start ignored during the IDLE cycle that still shows done.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_gap_enter = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !r_busy) begin
                    w_load = 1'b1;
                    w_next = (repeat_count == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    if (!w_more) begin
                        w_next = ST_DONE;
                    end else if (r_gap_len != '0) begin
                        w_next      = ST_GAP;
                        w_gap_enter = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rep     <= '0;
            r_gap_len <= '0;
            r_gap_cnt <= '0;
            r_out     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_load) begin
                r_rep     <= repeat_count;
                r_gap_len <= gap_len;
            end else if (w_shift && w_last) begin
                r_rep <= r_rep - CNT_W'(1);
            end

            if (w_gap_enter) begin
                r_gap_cnt <= r_gap_len;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end

            r_out   <= (r_state == ST_SHIFT) & w_bit;
            r_valid <= (r_state == ST_SHIFT);
            r_busy  <= (r_state != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
        end
    end

    assign sequence_out   = r_out;
    assign sequence_valid = r_valid;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
